// File: rtl/reg_access_sequencer_if.sv
// rtl/reg_access_sequencer_if.sv - instruction handshake and register-file port bundle
interface reg_access_sequencer_if;
    logic       INSTR_VALID;
    logic [7:0] INSTR;
    logic       INSTR_READY;
    logic [1:0] REG_SOURCE;
    logic [1:0] REG_TWO;
    logic [1:0] REG_DEST;
    logic       REGDST;
    logic       REGWRITE;
    logic [7:0] REG_WRITE_DATA;
    logic [7:0] READ_DATA_ONE;
    logic [7:0] READ_DATA_TWO;
    logic [1:0] IMM;
    logic       DONE;
    logic [7:0] RESULT;
    logic       OVF;

    modport master (
        input  INSTR_VALID, INSTR, READ_DATA_ONE, READ_DATA_TWO, IMM,
        output INSTR_READY, REG_SOURCE, REG_TWO, REG_DEST, REGDST, REGWRITE,
               REG_WRITE_DATA, DONE, RESULT, OVF
    );

    modport slave (
        output INSTR_VALID, INSTR, READ_DATA_ONE, READ_DATA_TWO, IMM,
        input  INSTR_READY, REG_SOURCE, REG_TWO, REG_DEST, REGDST, REGWRITE,
               REG_WRITE_DATA, DONE, RESULT, OVF
    );
endinterface

// File: rtl/reg_access_sequencer.sv
// rtl/reg_access_sequencer.sv - five-state issue/execute/arm/writeback sequencer for a 4x8 register file
module reg_access_sequencer (
    input  logic                  CLK,
    input  logic                  RST,
    reg_access_sequencer_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_EX, S_ARM, S_WB} state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDI = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [1:0] rs_q, rs_d;
    logic [1:0] rt_q, rt_d;
    logic [1:0] rd_q, rd_d;
    logic       regdst_q, regdst_d;
    logic       regwrite_q, regwrite_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] res_q, res_d;
    logic       res_ovf_q, res_ovf_d;
    logic       done_q, done_d;
    logic [7:0] result_q, result_d;
    logic       ovf_q, ovf_d;

    logic [7:0] operand_b;
    logic [7:0] carry_in;
    logic [7:0] alu_sum;
    logic       alu_ovf;

    // SUB is rs + ~rt + 1 so one overflow rule covers all three ops.
    always_comb begin
        operand_b = bus.READ_DATA_TWO;
        carry_in  = 8'd0;
        case (op_q)
            OP_SUB: begin
                operand_b = ~bus.READ_DATA_TWO;
                carry_in  = 8'd1;
            end
            OP_ADDI: operand_b = {{6{bus.IMM[1]}}, bus.IMM};
            default: ;
        endcase
        alu_sum = bus.READ_DATA_ONE + operand_b + carry_in;
        alu_ovf = (bus.READ_DATA_ONE[7] == operand_b[7]) && (alu_sum[7] != bus.READ_DATA_ONE[7]);
        if (op_q == OP_NOP) begin
            alu_sum = 8'd0;
            alu_ovf = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        regdst_d   = regdst_q;
        regwrite_d = regwrite_q;
        wdata_d    = wdata_q;
        res_d      = res_q;
        res_ovf_d  = res_ovf_q;
        done_d     = 1'b0;
        result_d   = result_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.INSTR_VALID) begin
                    op_d     = bus.INSTR[7:6];
                    rs_d     = bus.INSTR[5:4];
                    rt_d     = bus.INSTR[3:2];
                    rd_d     = bus.INSTR[1:0];
                    regdst_d = (bus.INSTR[7:6] != OP_ADDI);
                    state_d  = S_RD;
                end
            end
            S_RD: state_d = S_EX;
            S_EX: begin
                res_d      = alu_sum;
                res_ovf_d  = alu_ovf;
                // Park the inverse so the WB edge is guaranteed to be a data change.
                wdata_d    = ~alu_sum;
                regwrite_d = (op_q != OP_NOP);
                state_d    = S_ARM;
            end
            S_ARM: begin
                wdata_d  = res_q;
                done_d   = 1'b1;
                result_d = res_q;
                ovf_d    = res_ovf_q;
                state_d  = S_WB;
            end
            S_WB: begin
                regwrite_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            op_q       <= OP_ADD;
            rs_q       <= 2'd0;
            rt_q       <= 2'd0;
            rd_q       <= 2'd0;
            regdst_q   <= 1'b0;
            regwrite_q <= 1'b0;
            wdata_q    <= 8'd0;
            res_q      <= 8'd0;
            res_ovf_q  <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= 8'd0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            regdst_q   <= regdst_d;
            regwrite_q <= regwrite_d;
            wdata_q    <= wdata_d;
            res_q      <= res_d;
            res_ovf_q  <= res_ovf_d;
            done_q     <= done_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.INSTR_READY    = (state_q == S_IDLE);
    assign bus.REG_SOURCE     = rs_q;
    assign bus.REG_TWO        = rt_q;
    assign bus.REG_DEST       = rd_q;
    assign bus.REGDST         = regdst_q;
    assign bus.REGWRITE       = regwrite_q;
    assign bus.REG_WRITE_DATA = wdata_q;
    assign bus.DONE           = done_q;
    assign bus.RESULT         = result_q;
    assign bus.OVF            = ovf_q;
endmodule

// File: tb/tb_reg_access_sequencer.sv
// tb/tb_reg_access_sequencer.sv - scoreboard bench with a behavioural write-on-change register file
module tb_reg_access_sequencer;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    reg_access_sequencer_if bus ();
    reg_access_sequencer dut (.CLK(CLK), .RST(RST), .bus(bus));

    typedef struct {
        logic [7:0] res;
        logic       ovf;
        logic [1:0] tgt;
        logic       wr;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] exp_regs [0:3];
    int         checks = 0;
    int         passed = 0;

    // Register file: registered reads, commits only on a data change while the enable was already high.
    logic [7:0] regs [0:3];
    logic [7:0] wd_prev;
    logic       we_prev;
    logic       model_clr;
    logic       pre_en;
    logic [1:0] pre_idx;
    logic [7:0] pre_val;

    always @(posedge CLK) begin
        if (model_clr) begin
            for (int i = 0; i < 4; i++) regs[i] <= 8'd0;
            we_prev <= 1'b0;
            wd_prev <= 8'd0;
        end else begin
            if (pre_en) regs[pre_idx] <= pre_val;
            if (bus.REGWRITE && we_prev && (bus.REG_WRITE_DATA != wd_prev))
                regs[bus.REGDST ? bus.REG_DEST : bus.REG_TWO] <= bus.REG_WRITE_DATA;
            we_prev <= bus.REGWRITE;
            wd_prev <= bus.REG_WRITE_DATA;
        end
        bus.READ_DATA_ONE <= regs[bus.REG_SOURCE];
        bus.READ_DATA_TWO <= regs[bus.REG_TWO];
        bus.IMM           <= bus.REG_DEST;
    end

    function automatic exp_t model(input logic [7:0] ins);
        exp_t e;
        int sa, sb, si, sr;
        logic [7:0] a, b;
        logic [1:0] im;
        a  = exp_regs[ins[5:4]];
        b  = exp_regs[ins[3:2]];
        im = ins[1:0];
        sa = int'($signed(a));
        sb = int'($signed(b));
        si = int'($signed(im));
        case (ins[7:6])
            2'b00:   sr = sa + sb;
            2'b01:   sr = sa - sb;
            2'b10:   sr = sa + si;
            default: sr = 0;
        endcase
        e.res = sr[7:0];
        e.ovf = (sr > 127) || (sr < -128);
        e.tgt = (ins[7:6] == 2'b10) ? ins[3:2] : ins[1:0];
        e.wr  = (ins[7:6] != 2'b11);
        return e;
    endfunction

    task automatic preload(input logic [1:0] idx, input logic [7:0] val);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        exp_regs[idx] = val;
        @(posedge CLK); #1;
        pre_en = 1'b0;
        @(negedge CLK);
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (regs[i] !== exp_regs[i])
                $display("FAIL %s_r%0d: got %h expected %h", name, i, regs[i], exp_regs[i]);
            else passed++;
        end
    endtask

    // Called on a negedge in IDLE; returns on the negedge of the following IDLE cycle.
    task automatic run_instr(input logic [7:0] ins, input string name);
        exp_t e, f;
        int k;
        logic done_seen;
        logic [7:0] wd_arm;
        e = model(ins);
        sbq.push_back(e);
        if (e.wr) exp_regs[e.tgt] = e.res;
        checks++;
        if (bus.INSTR_READY !== 1'b1) $display("FAIL %s_ready: got %b expected 1", name, bus.INSTR_READY);
        else passed++;
        bus.INSTR_VALID = 1'b1;
        bus.INSTR = ins;
        @(posedge CLK); #1;
        bus.INSTR_VALID = 1'b0;
        bus.INSTR = 8'($urandom);
        k = 0; done_seen = 1'b0; wd_arm = 8'h00;
        while (!done_seen && k < 10) begin
            @(negedge CLK);
            k++;
            if (k == 1 && e.wr) begin
                checks++;
                if (bus.REGDST !== (ins[7:6] != 2'b10))
                    $display("FAIL %s_regdst: got %b expected %b", name, bus.REGDST, ins[7:6] != 2'b10);
                else passed++;
            end
            if (k == 3) wd_arm = bus.REG_WRITE_DATA;
            if (bus.DONE === 1'b1) done_seen = 1'b1;
        end
        checks++;
        if (!done_seen || k != 4) $display("FAIL %s_latency: got %0d cycles (done=%b) expected 4", name, k, done_seen);
        else passed++;
        f = sbq.pop_front();
        if (done_seen) begin
            checks++;
            if (bus.RESULT !== f.res) $display("FAIL %s_result: got %h expected %h", name, bus.RESULT, f.res);
            else passed++;
            checks++;
            if (bus.OVF !== f.ovf) $display("FAIL %s_ovf: got %b expected %b", name, bus.OVF, f.ovf);
            else passed++;
            checks++;
            if (bus.REGWRITE !== f.wr) $display("FAIL %s_wb_regwrite: got %b expected %b", name, bus.REGWRITE, f.wr);
            else passed++;
            if (f.wr) begin
                checks++;
                if (wd_arm !== ~f.res) $display("FAIL %s_wd_arm: got %h expected %h", name, wd_arm, ~f.res);
                else passed++;
                checks++;
                if (bus.REG_WRITE_DATA !== f.res) $display("FAIL %s_wd_wb: got %h expected %h", name, bus.REG_WRITE_DATA, f.res);
                else passed++;
            end
            @(negedge CLK);
        end
        checks++;
        if (bus.REGWRITE !== 1'b0 || bus.INSTR_READY !== 1'b1)
            $display("FAIL %s_idle: got regwrite=%b ready=%b expected 0/1", name, bus.REGWRITE, bus.INSTR_READY);
        else passed++;
        check_regs(name);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        model_clr = 1'b1;
        bus.INSTR_VALID = 1'b1;
        bus.INSTR = 8'h81;
        for (int i = 0; i < 4; i++) exp_regs[i] = 8'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_clr = 1'b0;
        bus.INSTR_VALID = 1'b0;
        checks++;
        if (bus.INSTR_READY !== 1'b1 || bus.REGWRITE !== 1'b0 || bus.DONE !== 1'b0 || bus.OVF !== 1'b0 || bus.REGDST !== 1'b0)
            $display("FAIL reset_ctrl: got ready=%b we=%b done=%b ovf=%b regdst=%b expected 1/0/0/0/0",
                     bus.INSTR_READY, bus.REGWRITE, bus.DONE, bus.OVF, bus.REGDST);
        else passed++;
        checks++;
        if ({bus.REG_SOURCE, bus.REG_TWO, bus.REG_DEST} !== 6'd0 || bus.REG_WRITE_DATA !== 8'd0 || bus.RESULT !== 8'd0)
            $display("FAIL reset_data: got addr=%h wd=%h result=%h expected 0/0/0",
                     {bus.REG_SOURCE, bus.REG_TWO, bus.REG_DEST}, bus.REG_WRITE_DATA, bus.RESULT);
        else passed++;
        @(negedge CLK);
        checks++;
        if (bus.INSTR_READY !== 1'b1) $display("FAIL reset_dominates: got ready=%b expected 1", bus.INSTR_READY);
        else passed++;
    endtask

    task automatic test_add;
        for (int i = 0; i < 5; i++) run_instr(8'h81, "addi_inc");
        run_instr(8'h01, "add_r1");
    endtask

    task automatic test_overflow;
        preload(2'd2, 8'h80);
        preload(2'd3, 8'h01);
        run_instr(8'h6C, "sub_ovf");
        run_instr(8'h0E, "add_ovf");
    endtask

    task automatic test_addi_neg;
        preload(2'd1, 8'h00);
        run_instr(8'h9E, "addi_neg");
    endtask

    task automatic test_back_to_back;
        preload(2'd0, 8'h05);
        run_instr(8'h01, "b2b_first");
        run_instr(8'h02, "b2b_same_val");
    endtask

    task automatic test_nop_stream;
        int done_cnt, we_cnt, last_done, bad_gap;
        done_cnt = 0; we_cnt = 0; last_done = 0; bad_gap = 0;
        bus.INSTR = 8'hC5;
        bus.INSTR_VALID = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge CLK);
            if (k == 15) bus.INSTR_VALID = 1'b0;
            if (bus.REGWRITE === 1'b1) we_cnt++;
            if (bus.DONE === 1'b1) begin
                if (k - last_done != (done_cnt == 0 ? 4 : 5)) bad_gap++;
                if (bus.RESULT !== 8'd0 || bus.OVF !== 1'b0) bad_gap++;
                last_done = k;
                done_cnt++;
            end
        end
        checks++;
        if (done_cnt != 3 || bad_gap != 0)
            $display("FAIL nop_done: got %0d pulses %0d bad expected 3 pulses 0 bad", done_cnt, bad_gap);
        else passed++;
        checks++;
        if (we_cnt != 0) $display("FAIL nop_regwrite: got %0d cycles expected 0", we_cnt);
        else passed++;
        @(negedge CLK);
        check_regs("nop");
    endtask

    task automatic test_reset_in_arm;
        int done_cnt;
        preload(2'd0, 8'h05);
        preload(2'd1, 8'h33);
        bus.INSTR = 8'h01;
        bus.INSTR_VALID = 1'b1;
        @(posedge CLK); #1;
        bus.INSTR_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (bus.REGWRITE !== 1'b1) $display("FAIL arm_regwrite: got %b expected 1", bus.REGWRITE);
        else passed++;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if (bus.INSTR_READY !== 1'b1 || bus.REGWRITE !== 1'b0 || bus.DONE !== 1'b0)
            $display("FAIL arm_reset: got ready=%b we=%b done=%b expected 1/0/0", bus.INSTR_READY, bus.REGWRITE, bus.DONE);
        else passed++;
        done_cnt = 0;
        repeat (6) begin
            @(negedge CLK);
            if (bus.DONE === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) $display("FAIL arm_no_done: got %0d pulses expected 0", done_cnt);
        else passed++;
        check_regs("arm_abort");
    endtask

    initial begin
        RST = 1'b1;
        model_clr = 1'b1;
        pre_en = 1'b0; pre_idx = 2'd0; pre_val = 8'd0;
        bus.INSTR_VALID = 1'b0;
        bus.INSTR = 8'd0;
        @(negedge CLK);
        test_reset();
        test_add();
        test_overflow();
        test_addi_neg();
        test_back_to_back();
        test_nop_stream();
        test_reset_in_arm();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
